// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
package nibble_serial_adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operand width must be a whole number of slices.
    function automatic bit width_ok(input int unsigned w);
        return (w >= SLICE_W) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// Existing 4-bit carry look-ahead adder slice.
module carry_look_ahead_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] S,
    output logic               Cout,
    output logic [SLICE_W:0]   out
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    // Generate/propagate terms and fully expanded look-ahead carries.
    always_comb begin
        p    = A ^ B;
        g    = A & B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
        S    = p ^ c[SLICE_W-1:0];
        Cout = c[SLICE_W];
        out  = {Cout, S};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit CLA slice reused over WIDTH/4 cycles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   out
);

    localparam int unsigned NIB   = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_shift_q, sum_shift_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic [SLICE_W:0]   slice_out_unused;

    carry_look_ahead_adder u_slice (
        .A    (a_q[SLICE_W-1:0]),
        .B    (b_q[SLICE_W-1:0]),
        .Cin  (carry_q),
        .S    (slice_s),
        .Cout (slice_cout),
        .out  (slice_out_unused)
    );

    // Next-state and datapath: accept in IDLE/DONE, consume one nibble per RUN cycle.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_shift_d = sum_shift_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d         = a_q >> SLICE_W;
                b_d         = b_q >> SLICE_W;
                carry_d     = slice_cout;
                idx_d       = idx_q + IDX_W'(1);
                sum_shift_d = (sum_shift_q >> SLICE_W)
                            | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
                if (idx_q == IDX_W'(NIB - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = sum_shift_d;
                    cout_d  = slice_cout;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_shift_q <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_shift_q <= sum_shift_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign out  = {cout_q, sum_q};

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances).
module tb_nibble_serial_adder;

    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic [W:0]   out;

    logic         start4, cin4;
    logic [3:0]   a4, b4;
    logic         busy4, done4, cout4;
    logic [3:0]   sum4;
    logic [4:0]   out4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .out(out)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .out(out4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start fixes the result a+b+cin, which
    // appears N cycles later for one cycle and is held until replaced.
    int         m_left = 0;
    bit         m_done = 1'b0;
    logic [W:0] m_res  = '0;
    logic [W:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_left = N;
                m_pend = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
            end
        end
    end

    // Cycle-by-cycle compare of the 16-bit instance against the model.
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_done));
        chk("out",  64'(out),  64'(m_res));
        chk("sum",  64'(sum),  64'(m_res[W-1:0]));
        chk("cout", 64'(cout), 64'(m_res[W]));
    end

    // Launch an op at the current negedge and wait for done; scrambles inputs
    // during RUN and optionally pulses start mid-run.
    task automatic go16(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W:0] exp, input string name, input bit glitch);
        int cyc = 0;
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (glitch && cyc == 2) begin
                start = 1'b1; a = 16'h5A5A; b = 16'hA5A5;
            end
            if (glitch && cyc == 3) start = 1'b0;
        end while (!done && cyc < 20);
        chk({name, "_latency"}, 64'(cyc), 64'(N + 1));
        chk({name, "_out"}, 64'(out), 64'(exp));
    endtask

    task automatic go4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                       input logic [4:0] exp, input string name);
        int cyc = 0;
        start4 = 1'b1; a4 = ta; b4 = tb_v; cin4 = tc;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start4 = 1'b0;
                chk({name, "_busy"}, 64'(busy4), 64'd1);
            end
        end while (!done4 && cyc < 20);
        chk({name, "_latency"}, 64'(cyc), 64'd2);
        chk({name, "_out"}, 64'(out4), 64'(exp));
        chk({name, "_sum"}, 64'(sum4), 64'(exp[3:0]));
        chk({name, "_cout"}, 64'(cout4), 64'(exp[4]));
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done4), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [3:0]   r4a, r4b;
        logic         r4c;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_out",  64'(out),  64'd0);
        chk("reset_out4", 64'(out4), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with literal results.
        go16(16'h8888, 16'h8888, 1'b1, 17'h11111, "c8888", 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        go16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "cffff", 1'b0);
        @(negedge clk);
        go16(16'h0000, 16'hFFFF, 1'b1, 17'h10000, "cprop", 1'b0);
        @(negedge clk);

        // Back-to-back: second start issued while first op is in DONE.
        go16(16'h1234, 16'h4321, 1'b0, 17'h05555, "b2b_first", 1'b0);
        go16(16'h0001, 16'h0001, 1'b0, 17'h00002, "b2b_second", 1'b0);
        @(negedge clk);

        // Start pulse during RUN is ignored; exactly one done follows.
        go16(16'h0F0F, 16'h0101, 1'b0, 17'h01010, "glitch", 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("glitch_no_extra_done", 64'(done), 64'd0);
        end

        // Reset in the middle of RUN aborts the op.
        start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end

        // Randomized ops with random gaps (zero gap gives back-to-back).
        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i % 10 == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            go16(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 17'(rc), "rand16", 1'b0);
        end
        @(negedge clk);

        // Single-slice instance.
        go4(4'hF, 4'h1, 1'b0, 5'h10, "w4_f1");
        go4(4'hF, 4'hF, 1'b1, 5'h1F, "w4_ff");
        for (int i = 0; i < 20; i++) begin
            r4a = 4'($urandom); r4b = 4'($urandom); r4c = 1'($urandom);
            go4(r4a, r4b, r4c, {1'b0, r4a} + {1'b0, r4b} + 5'(r4c), "w4_rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
